// File: rtl/imem_fetch_responder_if.sv
// Fetch-side instruction-read bus between the fetch stage and the
// instruction-memory responder.
//   master : fetch stage (drives request, flush and response acceptance)
//   slave  : responder   (drives req_ready and the registered response)
interface imem_fetch_responder_if;
    logic        req_valid;
    logic [63:0] req_pc;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_pc;
    logic [79:0] resp_bytes;
    logic        resp_imem_error;

    modport master (
        output req_valid, req_pc, flush, resp_ready,
        input  req_ready, resp_valid, resp_pc, resp_bytes, resp_imem_error
    );

    modport slave (
        input  req_valid, req_pc, flush, resp_ready,
        output req_ready, resp_valid, resp_pc, resp_bytes, resp_imem_error
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: returns the 10 bytes at a requested PC after
// LATENCY cycles, flags out-of-range PCs, supports flush and a byte load port.
//   clk, reset            : clock, synchronous active-high reset
//   load_en/addr/data     : program-load byte write (any state)
//   bus (slave)           : request/response handshake toward fetch
module imem_fetch_responder #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    imem_fetch_responder_if.slave bus
);
    localparam int unsigned IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned NBYTES  = 10;
    localparam int unsigned BYTES_W = 8 * NBYTES;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0] mem [MEM_BYTES];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pc_q, pc_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [63:0]        resp_pc_q, resp_pc_d;
    logic [BYTES_W-1:0] resp_bytes_q, resp_bytes_d;
    logic               err_q, err_d;

    logic [BYTES_W-1:0] rd_bytes;
    logic [64:0]        pc_end;
    logic               pc_err;

    // Program load; out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (load_en && (64'(load_addr) < 64'(MEM_BYTES))) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Ten-byte little-endian read window at the latched PC.
    always_comb begin
        rd_bytes = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            rd_bytes[8*k +: 8] = mem[pc_q[IDX_W-1:0] + IDX_W'(k)];
        end
    end

    // 65-bit end address: a non-negative PC cannot wrap here, so pc+9
    // overflow simply shows up as an end address past the memory.
    assign pc_end = {pc_q[63], pc_q} + 65'd9;
    assign pc_err = pc_q[63] || (pc_end > 65'(MEM_BYTES - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        resp_bytes_d = resp_bytes_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    pc_d        = bus.req_pc;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_pc_d    = pc_q;
                    resp_bytes_d = pc_err ? '0 : rd_bytes;
                    err_d        = pc_err;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.flush || bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pc_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            resp_bytes_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            resp_bytes_q <= resp_bytes_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_pc         = resp_pc_q;
    assign bus.resp_bytes      = resp_bytes_q;
    assign bus.resp_imem_error = err_q;
endmodule
